// File: rtl/risc_debug_pkg.sv
// Shared defaults and types for the RISC-V debug display path
// (register tracker, debug display and their benches).
package risc_debug_pkg;

    localparam int DEF_NUM_REGS    = 32;
    localparam int DEF_REG_W       = 32;
    localparam int DEF_HOLD_FRAMES = 30;
    localparam int DEF_CNT_W       = 16;

    typedef logic [DEF_REG_W-1:0] reg_word_t;
    typedef reg_word_t regfile_t [0:DEF_NUM_REGS-1];

    // Width of a down-counter that must hold values 0..holdFrames.
    function automatic int holdCntWidth(input int holdFrames);
        return $clog2(holdFrames + 1);
    endfunction

endpackage

// File: rtl/risc_reg_tracker_if.sv
// Writeback/frame-control inputs and display-facing outputs of the register tracker.
// master = core/VGA side driving writes and ticks, slave = the tracker itself.
interface risc_reg_tracker_if
    import risc_debug_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int REG_W    = DEF_REG_W,
    parameter int CNT_W    = DEF_CNT_W
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic                 wb_we;
    logic [IDX_W-1:0]     wb_rd;
    logic [REG_W-1:0]     wb_data;
    logic                 frame_tick;
    logic                 freeze;

    logic [REG_W-1:0]     regs_view [0:NUM_REGS-1];
    logic [NUM_REGS-1:0]  changed_mask;
    logic [IDX_W-1:0]     last_rd;
    logic [CNT_W-1:0]     write_count;

    modport master (
        output wb_we, wb_rd, wb_data, frame_tick, freeze,
        input  regs_view, changed_mask, last_rd, write_count
    );

    modport slave (
        input  wb_we, wb_rd, wb_data, frame_tick, freeze,
        output regs_view, changed_mask, last_rd, write_count
    );

endinterface

// File: rtl/reg_hold_cell.sv
// Per-register highlight state: a pending-change flag collected during the frame,
// a hold counter that stretches the highlight across HOLD_FRAMES video frames,
// and the registered highlight bit shown to the display.
module reg_hold_cell
    import risc_debug_pkg::*;
#(
    parameter int HOLD_FRAMES = DEF_HOLD_FRAMES
) (
    input  logic clock,
    input  logic reset,
    input  logic set_pending,
    input  logic tick_en,
    output logic highlight
);
    localparam int             CW       = holdCntWidth(HOLD_FRAMES);
    localparam logic [CW-1:0]  HOLD_VAL = CW'(HOLD_FRAMES);

    logic          r_pending;
    logic [CW-1:0] r_count;
    logic          r_highlight;
    logic [CW-1:0] w_countNext;

    // Counter value for the coming frame: a pending change reloads, otherwise count down to 0.
    always_comb begin
        w_countNext = r_count;
        if (r_pending) begin
            w_countNext = HOLD_VAL;
        end else if (r_count != '0) begin
            w_countNext = r_count - CW'(1);
        end
    end

    // Frame boundary advances counter/mask and restarts pending collection; a change in the same cycle wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending   <= 1'b0;
            r_count     <= '0;
            r_highlight <= 1'b0;
        end else if (tick_en) begin
            r_count     <= w_countNext;
            r_highlight <= (w_countNext != '0);
            r_pending   <= set_pending;
        end else if (set_pending) begin
            r_pending   <= 1'b1;
        end
    end

    assign highlight = r_highlight;

endmodule

// File: rtl/risc_reg_tracker.sv
// Shadows the core writeback port and presents a frame-stable register image plus
// a change-highlight mask to the VGA debug display. The live image follows every
// accepted write; the displayed image and mask only move on unfrozen frame ticks.
module risc_reg_tracker
    import risc_debug_pkg::*;
#(
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int REG_W       = DEF_REG_W,
    parameter int HOLD_FRAMES = DEF_HOLD_FRAMES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                     clock,
    input  logic                     sw0,
    risc_reg_tracker_if.slave        bus
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic [REG_W-1:0]    r_live [0:NUM_REGS-1];
    logic [REG_W-1:0]    r_view [0:NUM_REGS-1];
    logic [IDX_W-1:0]    r_lastRd;
    logic [CNT_W-1:0]    r_writeCount;

    logic                w_accept;
    logic                w_tickEn;
    logic [NUM_REGS-1:1] w_setPending;
    logic [NUM_REGS-1:0] w_highlight;

    // x0 is hardwired zero on the core, so writes to it are dropped entirely.
    assign w_accept = bus.wb_we && (bus.wb_rd != '0);
    assign w_tickEn = bus.frame_tick && !bus.freeze;

    // A write only counts as a change when it differs from the live value it replaces.
    always_comb begin
        w_setPending = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (w_accept && (bus.wb_rd == IDX_W'(i)) && (bus.wb_data != r_live[i])) begin
                w_setPending[i] = 1'b1;
            end
        end
    end

    // Live register image, updated on every accepted write regardless of freeze.
    always_ff @(posedge clock) begin
        if (sw0) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_live[i] <= '0;
            end
        end else if (w_accept) begin
            r_live[bus.wb_rd] <= bus.wb_data;
        end
    end

    // Displayed image snapshots the pre-edge live image at each unfrozen frame tick.
    always_ff @(posedge clock) begin
        if (sw0) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_view[i] <= '0;
            end
        end else if (w_tickEn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_view[i] <= r_live[i];
            end
        end
    end

    // Most recent destination and a saturating count of accepted writes.
    always_ff @(posedge clock) begin
        if (sw0) begin
            r_lastRd     <= '0;
            r_writeCount <= '0;
        end else if (w_accept) begin
            r_lastRd <= bus.wb_rd;
            if (r_writeCount != '1) begin
                r_writeCount <= r_writeCount + CNT_W'(1);
            end
        end
    end

    assign w_highlight[0] = 1'b0;

    generate
        for (genvar g = 1; g < NUM_REGS; g++) begin : g_cell
            reg_hold_cell #(
                .HOLD_FRAMES (HOLD_FRAMES)
            ) u_cell (
                .clock       (clock),
                .reset       (sw0),
                .set_pending (w_setPending[g]),
                .tick_en     (w_tickEn),
                .highlight   (w_highlight[g])
            );
        end

        for (genvar g = 0; g < NUM_REGS; g++) begin : g_view
            assign bus.regs_view[g] = r_view[g];
        end
    endgenerate

    assign bus.changed_mask = w_highlight;
    assign bus.last_rd      = r_lastRd;
    assign bus.write_count  = r_writeCount;

endmodule

// File: tb/tb_risc_reg_tracker.sv
// Bench for risc_reg_tracker: directed scenarios plus randomized writeback traffic,
// checked by a scoreboard fed from a frame-level reference model.
module tb_risc_reg_tracker;
    import risc_debug_pkg::*;

    localparam int NREG        = 32;
    localparam int RW          = 32;
    localparam int HOLD        = 3;
    localparam int CW          = 16;
    localparam int TICK_PERIOD = 20;

    logic clock = 1'b0;
    logic sw0   = 1'b1;

    always #5 clock = ~clock;

    risc_reg_tracker_if #(.NUM_REGS(NREG), .REG_W(RW), .CNT_W(CW)) bus();

    risc_reg_tracker #(
        .NUM_REGS    (NREG),
        .REG_W       (RW),
        .HOLD_FRAMES (HOLD),
        .CNT_W       (CW)
    ) dut (
        .clock (clock),
        .sw0   (sw0),
        .bus   (bus)
    );

    typedef struct {
        int unsigned                 cycle;
        logic [NREG-1:0][RW-1:0]     view;
        logic [NREG-1:0]             mask;
        logic [4:0]                  lastRd;
        logic [CW-1:0]               wc;
    } exp_t;

    exp_t        expQ[$];
    int          testsRun    = 0;
    int          testsFailed = 0;
    int unsigned cycleCnt    = 0;
    int          tickPhase   = 0;

    // Reference model: registers as values, highlight as "which frame did it start in".
    regfile_t        mLive;
    regfile_t        mView;
    bit              mPending [NREG];
    bit              mStarted [NREG];
    int unsigned     mStart   [NREG];
    int unsigned     mTickIdx;
    logic [NREG-1:0] mMask;
    logic [4:0]      mLastRd;
    logic [CW-1:0]   mCount;

    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    task automatic modelReset();
        for (int i = 0; i < NREG; i++) begin
            mLive[i]    = '0;
            mView[i]    = '0;
            mPending[i] = 1'b0;
            mStarted[i] = 1'b0;
            mStart[i]   = 0;
        end
        mTickIdx = 0;
        mMask    = '0;
        mLastRd  = '0;
        mCount   = '0;
    endtask

    task automatic modelStep(input logic we, input logic [4:0] rd, input logic [31:0] data,
                             input logic tick, input logic frz, input logic rst);
        bit accept;
        bit differ;
        if (rst) begin
            modelReset();
            return;
        end
        accept = we && (rd != 0);
        differ = accept && (data != mLive[rd]);
        if (tick && !frz) begin
            mTickIdx++;
            for (int i = 0; i < NREG; i++) begin
                mView[i] = mLive[i];
                if (mPending[i]) begin
                    mStarted[i] = 1'b1;
                    mStart[i]   = mTickIdx;
                end
                mPending[i] = 1'b0;
                mMask[i]    = mStarted[i] && ((mTickIdx - mStart[i]) < HOLD);
            end
        end
        if (differ) mPending[rd] = 1'b1;
        if (accept) begin
            mLive[rd] = data;
            mLastRd   = rd;
            if (mCount != '1) mCount = mCount + 1'b1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, advance the model, and queue the expected post-edge state.
    task automatic applyStimulus(input logic we, input logic [4:0] rd, input logic [31:0] data,
                                 input logic frz, input logic rst, input bit doCheck);
        logic tick;
        exp_t e;
        tick           = (tickPhase == TICK_PERIOD - 1);
        bus.wb_we      = we;
        bus.wb_rd      = rd;
        bus.wb_data    = data;
        bus.frame_tick = tick;
        bus.freeze     = frz;
        sw0            = rst;
        modelStep(we, rd, data, tick, frz, rst);
        if (doCheck) begin
            e.cycle = cycleCnt + 1;
            for (int i = 0; i < NREG; i++) e.view[i] = mView[i];
            e.mask   = mMask;
            e.lastRd = mLastRd;
            e.wc     = mCount;
            expQ.push_back(e);
        end
        @(posedge clock);
        #2;
        tickPhase = (tickPhase + 1) % TICK_PERIOD;
    endtask

    task automatic idleUntilTickNext(input logic frz);
        while (tickPhase != TICK_PERIOD - 1) applyStimulus(1'b0, 5'd0, 32'd0, frz, 1'b0, 1'b1);
    endtask

    task automatic waitTicks(input int n, input logic frz);
        repeat (n) begin
            idleUntilTickNext(frz);
            applyStimulus(1'b0, 5'd0, 32'd0, frz, 1'b0, 1'b1);
        end
    endtask

    // Write on a cycle that is not a frame tick.
    task automatic writeReg(input logic [4:0] rd, input logic [31:0] data, input logic frz);
        if (tickPhase == TICK_PERIOD - 1) applyStimulus(1'b0, 5'd0, 32'd0, frz, 1'b0, 1'b1);
        applyStimulus(1'b1, rd, data, frz, 1'b0, 1'b1);
    endtask

    // Monitor: once the targeted edge has passed, compare the DUT against the queued expectation.
    initial begin : monitor
        exp_t e;
        int   bad;
        forever begin
            @(negedge clock);
            while (expQ.size() > 0 && expQ[0].cycle <= cycleCnt) begin
                e   = expQ.pop_front();
                bad = -1;
                for (int i = 0; i < NREG; i++) begin
                    if (bad < 0 && bus.regs_view[i] !== e.view[i]) bad = i;
                end
                testsRun++;
                if (bad >= 0) begin
                    testsFailed++;
                    $display("[TB] FAIL regs_view[%0d] @cycle %0d: got 0x%08h, expected 0x%08h",
                             bad, e.cycle, bus.regs_view[bad], e.view[bad]);
                end
                checkOutput("changed_mask", bus.changed_mask, e.mask);
                checkOutput("last_rd", 32'(bus.last_rd), 32'(e.lastRd));
                checkOutput("write_count", 32'(bus.write_count), 32'(e.wc));
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected bench to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic frozen;
        bus.wb_we      = 1'b0;
        bus.wb_rd      = '0;
        bus.wb_data    = '0;
        bus.frame_tick = 1'b0;
        bus.freeze     = 1'b0;
        modelReset();
        @(posedge clock);
        #2;

        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("reset mask", bus.changed_mask, 32'h0);
        checkOutput("reset write_count", 32'(bus.write_count), 32'h0);

        // Single write highlighted for HOLD frames
        writeReg(5'd5, 32'hDEADBEEF, 1'b0);
        checkOutput("x5 last_rd", 32'(bus.last_rd), 32'd5);
        checkOutput("x5 write_count", 32'(bus.write_count), 32'd1);
        waitTicks(1, 1'b0);
        checkOutput("x5 view", bus.regs_view[5], 32'hDEADBEEF);
        checkOutput("x5 mask tick1", bus.changed_mask, 32'h0000_0020);
        waitTicks(2, 1'b0);
        checkOutput("x5 mask tick3", bus.changed_mask, 32'h0000_0020);
        waitTicks(1, 1'b0);
        checkOutput("x5 mask tick4", bus.changed_mask, 32'h0);

        // x0 ignored, same-value rewrite counted but not highlighted
        writeReg(5'd0, 32'h1234, 1'b0);
        checkOutput("x0 write_count", 32'(bus.write_count), 32'd1);
        waitTicks(1, 1'b0);
        checkOutput("x0 view", bus.regs_view[0], 32'h0);
        checkOutput("x0 mask", bus.changed_mask, 32'h0);
        writeReg(5'd5, 32'hDEADBEEF, 1'b0);
        checkOutput("same-value write_count", 32'(bus.write_count), 32'd2);
        waitTicks(1, 1'b0);
        checkOutput("same-value mask", bus.changed_mask, 32'h0);

        // Write coincident with frame tick lands in the next frame
        idleUntilTickNext(1'b0);
        applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1);
        checkOutput("x7 view same tick", bus.regs_view[7], 32'h0);
        checkOutput("x7 bit same tick", 32'(bus.changed_mask[7]), 32'd0);
        waitTicks(1, 1'b0);
        checkOutput("x7 view next tick", bus.regs_view[7], 32'hA5A5A5A5);
        checkOutput("x7 bit next tick", 32'(bus.changed_mask[7]), 32'd1);
        waitTicks(3, 1'b0);
        checkOutput("x7 mask expired", bus.changed_mask, 32'h0);

        // Freeze holds view/mask while live tracking continues
        writeReg(5'd1, 32'd1, 1'b1);
        writeReg(5'd2, 32'd2, 1'b1);
        waitTicks(3, 1'b1);
        checkOutput("frozen view x1", bus.regs_view[1], 32'h0);
        checkOutput("frozen view x2", bus.regs_view[2], 32'h0);
        checkOutput("frozen mask", bus.changed_mask, 32'h0);
        checkOutput("frozen write_count", 32'(bus.write_count), 32'd5);
        waitTicks(1, 1'b0);
        checkOutput("thaw view x1", bus.regs_view[1], 32'd1);
        checkOutput("thaw view x2", bus.regs_view[2], 32'd2);
        checkOutput("thaw mask", bus.changed_mask, 32'h6);

        // Randomized traffic with freeze windows and occasional resets
        frozen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (tickPhase == 0) frozen = ($urandom_range(0, 3) == 0);
            applyStimulus(($urandom_range(0, 2) == 0),
                          5'($urandom_range(0, 31)),
                          ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : 32'($urandom),
                          frozen,
                          ($urandom_range(0, 599) == 0),
                          1'b1);
        end

        // Reset mid-frame discards a pending write
        writeReg(5'd9, 32'h5555_AAAA, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("midreset mask", bus.changed_mask, 32'h0);
        checkOutput("midreset last_rd", 32'(bus.last_rd), 32'h0);
        checkOutput("midreset write_count", 32'(bus.write_count), 32'h0);
        waitTicks(1, 1'b0);
        checkOutput("midreset view x9", bus.regs_view[9], 32'h0);
        checkOutput("midreset mask after tick", bus.changed_mask, 32'h0);

        // Saturation of write_count
        for (int k = 0; k < 65540; k++) begin
            applyStimulus(1'b1, 5'($urandom_range(1, 31)), 32'($urandom), 1'b0, 1'b0,
                          ((k % 8192) == 0) || (k > 65530));
        end
        checkOutput("write_count saturated", 32'(bus.write_count), 32'h0000_FFFF);

        @(negedge clock);
        #1;
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard drain: got %0d entries left, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
